// File: rtl/bringup_scheduler.sv
// bringup_scheduler
// Walks a host-supplied pin mask and drives one pin at a time with a square
// wave. Each visit lasts a fixed number of periods and is followed by an
// all-low quiet gap, so a probe can identify each pin by the time at which it
// moves. A looping command repeats the mask until stop is raised.

module bringup_scheduler #(
    parameter int NUM_PINS         = 16,
    parameter int CLOCKS_PER_CYCLE = 120,
    parameter int CYCLES_PER_PIN   = 8,
    parameter int GAP_CLOCKS       = 60,
    localparam int IDX_W           = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [NUM_PINS-1:0] cmd_mask,
    input  logic                cmd_loop,
    input  logic                stop,
    output logic [NUM_PINS-1:0] pins_o,
    output logic [IDX_W-1:0]    active_idx,
    output logic                active_valid,
    output logic                busy,
    output logic                done
);

    localparam int HALF   = CLOCKS_PER_CYCLE / 2;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int TOG_W  = $clog2(2 * CYCLES_PER_PIN + 1);
    localparam int GAP_W  = (GAP_CLOCKS > 0) ? $clog2(GAP_CLOCKS + 1) : 1;

    // Reload values and terminal counts, sized to their counters. The gap
    // counter counts down from GAP_CLOCKS-1 so that exactly GAP_CLOCKS
    // cycles are spent in GAP.
    localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(HALF - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST    = TOG_W'(2 * CYCLES_PER_PIN - 1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD  =
        GAP_W'((GAP_CLOCKS > 0) ? (GAP_CLOCKS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [NUM_PINS-1:0] mask_q;
    logic [NUM_PINS-1:0] mask_n;
    logic                loop_q;
    logic                loop_n;
    logic [NUM_PINS-1:0] pins_n;
    logic [IDX_W-1:0]    idx_n;
    logic                valid_n;
    logic                done_n;
    logic [HALF_W-1:0]   half_cnt;
    logic [HALF_W-1:0]   half_n;
    logic [TOG_W-1:0]    tog_cnt;
    logic [TOG_W-1:0]    tog_n;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_n;

    logic                cmd_low_found;
    logic [IDX_W-1:0]    cmd_low_idx;
    logic                low_found;
    logic [IDX_W-1:0]    low_idx;
    logic                above_found;
    logic [IDX_W-1:0]    above_idx;

    logic                enter_go;
    logic [IDX_W-1:0]    enter_idx;
    logic                do_select;

    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && !stop;

    // Priority scans: lowest set bit of the incoming command mask, lowest
    // set bit of the latched mask, and lowest latched bit above the pin
    // currently being visited. Scanning from the top down lets the lowest
    // match overwrite any higher one.
    always_comb begin
        cmd_low_found = 1'b0;
        cmd_low_idx   = '0;
        low_found     = 1'b0;
        low_idx       = '0;
        above_found   = 1'b0;
        above_idx     = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (cmd_mask[i]) begin
                cmd_low_found = 1'b1;
                cmd_low_idx   = IDX_W'(i);
            end
            if (mask_q[i]) begin
                low_found = 1'b1;
                low_idx   = IDX_W'(i);
            end
            if (mask_q[i] && (i > int'(active_idx))) begin
                above_found = 1'b1;
                above_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic. Entering DRIVE and choosing the next
    // pin are shared by several paths, so they are raised as flags and
    // resolved after the state case. Stop is applied last so that it wins
    // over everything else in any busy state.
    always_comb begin
        state_n   = state;
        mask_n    = mask_q;
        loop_n    = loop_q;
        pins_n    = pins_o;
        idx_n     = active_idx;
        valid_n   = active_valid;
        done_n    = 1'b0;
        half_n    = half_cnt;
        tog_n     = tog_cnt;
        gap_n     = gap_cnt;
        enter_go  = 1'b0;
        enter_idx = '0;
        do_select = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    mask_n = cmd_mask;
                    loop_n = cmd_loop;
                    if (cmd_low_found) begin
                        enter_go  = 1'b1;
                        enter_idx = cmd_low_idx;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            DRIVE: begin
                if (half_cnt != '0) begin
                    half_n = half_cnt - 1'b1;
                end else if (tog_cnt == TOG_LAST) begin
                    pins_n = '0;
                    tog_n  = tog_cnt + 1'b1;
                    if (GAP_CLOCKS == 0) begin
                        do_select = 1'b1;
                    end else begin
                        state_n = GAP;
                        valid_n = 1'b0;
                        gap_n   = GAP_RELOAD;
                    end
                end else begin
                    pins_n[active_idx] = ~pins_o[active_idx];
                    half_n             = HALF_RELOAD;
                    tog_n              = tog_cnt + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt != '0) begin
                    gap_n = gap_cnt - 1'b1;
                end else begin
                    do_select = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                pins_n  = '0;
                valid_n = 1'b0;
            end
        endcase

        if (do_select) begin
            if (above_found) begin
                enter_go  = 1'b1;
                enter_idx = above_idx;
            end else if (loop_q && low_found) begin
                enter_go  = 1'b1;
                enter_idx = low_idx;
            end else begin
                state_n = IDLE;
                pins_n  = '0;
                valid_n = 1'b0;
                done_n  = 1'b1;
            end
        end

        if (enter_go) begin
            state_n = DRIVE;
            pins_n  = '0;
            idx_n   = enter_idx;
            valid_n = 1'b1;
            half_n  = HALF_RELOAD;
            tog_n   = '0;
        end

        if ((state != IDLE) && stop) begin
            state_n = IDLE;
            pins_n  = '0;
            valid_n = 1'b0;
            done_n  = 1'b1;
        end
    end

    // State register plus registered outputs and counters; reset clears all.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mask_q       <= '0;
            loop_q       <= 1'b0;
            pins_o       <= '0;
            active_idx   <= '0;
            active_valid <= 1'b0;
            done         <= 1'b0;
            half_cnt     <= '0;
            tog_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_n;
            mask_q       <= mask_n;
            loop_q       <= loop_n;
            pins_o       <= pins_n;
            active_idx   <= idx_n;
            active_valid <= valid_n;
            done         <= done_n;
            half_cnt     <= half_n;
            tog_cnt      <= tog_n;
            gap_cnt      <= gap_n;
        end
    end

endmodule

// File: tb/tb_bringup_scheduler.sv
// Bench for bringup_scheduler: two instances (a quiet gap of 3 clocks and a
// zero gap) share one stimulus stream. A visit-position reference model
// predicts every output frame, frames are queued per instance, and a monitor
// pops and compares them one clock edge later.

module tb_bringup_scheduler;

    localparam int NP        = 4;
    localparam int CPC       = 4;
    localparam int CPP       = 2;
    localparam int GAP       = 3;
    localparam int HALF      = CPC / 2;
    localparam int DRIVE_LEN = 2 * CPP * HALF;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [NP-1:0] cmd_mask;
    logic          cmd_loop;
    logic          stop;

    logic          a_ready, a_valid, a_busy, a_done;
    logic [NP-1:0] a_pins;
    logic [1:0]    a_idx;
    logic          b_ready, b_valid, b_busy, b_done;
    logic [NP-1:0] b_pins;
    logic [1:0]    b_idx;

    typedef struct {
        logic [NP-1:0] pins;
        bit            valid;
        int            idx;
        bit            chk_idx;
        bit            busy;
        bit            done;
    } frame_t;

    typedef struct {
        bit            idle;
        bit            loop;
        logic [NP-1:0] mask;
        int            cur;
        int            pos;
    } model_t;

    frame_t q_a[$];
    frame_t q_b[$];
    model_t m_a;
    model_t m_b;
    int     n_cmp = 0;
    int     n_err = 0;
    bit     ready_known = 1'b0;

    always #5 clock = ~clock;

    bringup_scheduler #(
        .NUM_PINS(NP), .CLOCKS_PER_CYCLE(CPC), .CYCLES_PER_PIN(CPP), .GAP_CLOCKS(GAP)
    ) dut_a (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_mask(cmd_mask), .cmd_loop(cmd_loop), .stop(stop), .pins_o(a_pins),
        .active_idx(a_idx), .active_valid(a_valid), .busy(a_busy), .done(a_done)
    );

    bringup_scheduler #(
        .NUM_PINS(NP), .CLOCKS_PER_CYCLE(CPC), .CYCLES_PER_PIN(CPP), .GAP_CLOCKS(0)
    ) dut_b (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_mask(cmd_mask), .cmd_loop(cmd_loop), .stop(stop), .pins_o(b_pins),
        .active_idx(b_idx), .active_valid(b_valid), .busy(b_busy), .done(b_done)
    );

    // Lowest set bit of mask strictly above 'above', or -1 when none.
    function automatic int next_set(input logic [NP-1:0] mask, input int above);
        for (int i = above + 1; i < NP; i++) begin
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: a visit is DRIVE_LEN drive clocks followed by gap
    // quiet clocks; the pin level is the parity of how many half periods
    // have elapsed since the visit began.
    function automatic model_t model_step(input int gap, input model_t mi,
                                          input bit rst, input bit cv,
                                          input logic [NP-1:0] cm, input bit cl,
                                          input bit st, output frame_t f);
        model_t m;
        int     nxt;
        bit     dn;
        m  = mi;
        dn = 1'b0;
        if (rst) begin
            m.idle = 1'b1; m.loop = 1'b0; m.mask = '0; m.cur = 0; m.pos = 0;
        end else if (m.idle) begin
            if (cv && !st) begin
                m.mask = cm;
                m.loop = cl;
                if (cm == '0) begin
                    dn = 1'b1;
                end else begin
                    m.idle = 1'b0; m.cur = next_set(cm, -1); m.pos = 0;
                end
            end
        end else if (st) begin
            m.idle = 1'b1;
            dn     = 1'b1;
        end else begin
            m.pos++;
            if (m.pos == DRIVE_LEN + gap) begin
                nxt = next_set(m.mask, m.cur);
                if (nxt < 0 && m.loop) nxt = next_set(m.mask, -1);
                if (nxt >= 0) begin
                    m.cur = nxt; m.pos = 0;
                end else begin
                    m.idle = 1'b1; dn = 1'b1;
                end
            end
        end
        f.done    = dn;
        f.busy    = !m.idle;
        f.chk_idx = rst;
        f.idx     = 0;
        f.valid   = 1'b0;
        f.pins    = '0;
        if (!m.idle && m.pos < DRIVE_LEN) begin
            f.valid   = 1'b1;
            f.chk_idx = 1'b1;
            f.idx     = m.cur;
            if (((m.pos / HALF) % 2) == 1) f.pins = NP'(1) << m.cur;
        end
        return m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, check the combinational ready,
    // then advance both models and queue the frames expected after the edge.
    task automatic applyStimulus(input bit rst, input bit cv, input logic [NP-1:0] cm,
                                 input bit cl, input bit st);
        frame_t fa;
        frame_t fb;
        @(negedge clock);
        reset     = rst;
        cmd_valid = cv;
        cmd_mask  = cm;
        cmd_loop  = cl;
        stop      = st;
        #1;
        if (ready_known) begin
            checkOutput("cmd_ready_a", int'(a_ready), int'(m_a.idle && !st));
            checkOutput("cmd_ready_b", int'(b_ready), int'(m_b.idle && !st));
        end
        m_a = model_step(GAP, m_a, rst, cv, cm, cl, st, fa);
        m_b = model_step(0, m_b, rst, cv, cm, cl, st, fb);
        q_a.push_back(fa);
        q_b.push_back(fb);
        if (rst) ready_known = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: every clock, compare the DUT outputs with the next queued frame.
    initial begin
        frame_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checkOutput("pins_a",  int'(a_pins),  int'(e.pins));
                checkOutput("valid_a", int'(a_valid), int'(e.valid));
                checkOutput("busy_a",  int'(a_busy),  int'(e.busy));
                checkOutput("done_a",  int'(a_done),  int'(e.done));
                if (e.chk_idx) checkOutput("idx_a", int'(a_idx), e.idx);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checkOutput("pins_b",  int'(b_pins),  int'(e.pins));
                checkOutput("valid_b", int'(b_valid), int'(e.valid));
                checkOutput("busy_b",  int'(b_busy),  int'(e.busy));
                checkOutput("done_b",  int'(b_done),  int'(e.done));
                if (e.chk_idx) checkOutput("idx_b", int'(b_idx), e.idx);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_mask  = '0;
        cmd_loop  = 1'b0;
        stop      = 1'b0;
        m_a       = '{idle: 1'b1, loop: 1'b0, mask: '0, cur: 0, pos: 0};
        m_b       = m_a;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(2);

        $display("[TB] mask 0101, no loop");
        applyStimulus(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
        idleCycles(28);

        $display("[TB] empty mask");
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
        idleCycles(3);

        $display("[TB] mask 1000 looping, stop at t+15");
        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        idleCycles(14);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idleCycles(3);

        $display("[TB] command while busy is ignored");
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        idleCycles(20);

        $display("[TB] stop blocks acceptance in idle");
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1);
        idleCycles(3);

        $display("[TB] reset mid-drive, then restart");
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        idleCycles(15);

        $display("[TB] mask 0011");
        applyStimulus(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        idleCycles(30);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0,
                          NP'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 59) == 0);
        end
        idleCycles(2);

        @(posedge clock);
        #2;
        checkOutput("queue_drain", q_a.size() + q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
